// File: rtl/mdu_div_iter.sv
// mdu_div_iter -- iterative radix-2 restoring divider, responder side of the
// MDU start/done handshake.
//
// A one-cycle DIV (signed) or DIVU (unsigned) request is accepted while idle.
// The divider then runs WIDTH shift/subtract steps on operand magnitudes.
// One final cycle applies the sign correction and registers the result.
// done is high exactly when the unit is idle and result is valid. The
// initiator commits HI/LO on the rising edge of done.
//
// Optional feature (macro DIV_EARLY_OUT_EN):
//   When the divisor magnitude is nonzero and the dividend magnitude is
//   smaller, the iterations are skipped. The quotient is 0 and the remainder
//   is |dividend|, so the request completes two cycles after acceptance.
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous reset, active-high
//   div_op    2'b10 = DIV (signed), 2'b01 = DIVU (unsigned), else no request
//   dividend  numerator, sampled only on acceptance
//   divisor   denominator, sampled only on acceptance
//   result    {remainder (HI), quotient (LO)}
//   done      1 = idle with result valid, 0 = divide in progress
module mdu_div_iter #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         div_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] result,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvsr;
    logic               neg_rem;
    logic               neg_quo;

    logic               accept;
    logic               op_signed;
    logic               dvd_neg;
    logic               dvs_neg;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic               early;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        accept    = 1'b0;
        op_signed = 1'b0;
        dvd_neg   = 1'b0;
        dvs_neg   = 1'b0;
        dvd_mag   = dividend;
        dvs_mag   = divisor;
        early     = 1'b0;
        state_nxt = state;

        accept    = (state == S_IDLE) && (div_op == 2'b10 || div_op == 2'b01);
        op_signed = (div_op == 2'b10);
        dvd_neg   = op_signed & dividend[WIDTH-1];
        dvs_neg   = op_signed & divisor[WIDTH-1];
        // The magnitude of the most negative value fits in WIDTH unsigned bits.
        if (dvd_neg) dvd_mag = -dividend;
        if (dvs_neg) dvs_mag = -divisor;
`ifdef DIV_EARLY_OUT_EN
        early = (dvs_mag != '0) && (dvd_mag < dvs_mag);
`else
        early = 1'b0;
`endif

        // The partial remainder is always below 2*divisor (or below 2^WIDTH
        // when the divisor is zero). The top bit of the WIDTH+1-bit trial is
        // therefore a valid borrow flag.
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};

        quo_fix = neg_quo ? -quo : quo;
        rem_fix = neg_rem ? -rem : rem;

        case (state)
            S_IDLE:  if (accept) state_nxt = early ? S_FIX : S_ITER;
            S_ITER:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            neg_rem <= 1'b0;
            neg_quo <= 1'b0;
            result  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dvsr    <= dvs_mag;
                        cnt     <= '0;
                        neg_rem <= dvd_neg;
                        neg_quo <= dvd_neg ^ dvs_neg;
                        if (early) begin
                            rem <= dvd_mag;
                            quo <= '0;
                        end else begin
                            rem <= '0;
                            quo <= dvd_mag;
                        end
                    end
                end
                S_ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                end
                S_FIX: begin
                    result <= {rem_fix, quo_fix};
                end
                default: ;
            endcase
        end
    end

    assign done = (state == S_IDLE);

endmodule

// File: tb/tb_mdu_div_iter.sv
module tb_mdu_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [63:0] result;
    logic        done;

    int errors = 0;
    int checks = 0;

    mdu_div_iter dut (
        .clk      (clk),
        .rst      (rst),
        .div_op   (div_op),
        .dividend (dividend),
        .divisor  (divisor),
        .result   (result),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division on the architectural rules.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        if (op == 2'b01) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return {a, (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Expected cycles from request (T) until done is high again.
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        longint ma, mb;
        if (op == 2'b10) begin
            ma = longint'($signed(a));
            mb = longint'($signed(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = longint'(a);
            mb = longint'(b);
        end
        if (mb != 0 && ma < mb) return 2;
`else
        if (op == 2'b00 && a == b) return 34;
`endif
        return 34;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and measure the cycles until done rises.
    // Cycle 1 is the cycle just after the request edge.
    task automatic do_req(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        div_op   = op;
        dividend = a;
        divisor  = b;
        tick();
        div_op   = 2'b00;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_one(input string name, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [63:0] exp;
        int el;
        exp = model(op, a, b);
        el  = exp_lat(op, a, b);
        do_req(op, a, b, lat);
        checks++;
        if (lat !== el) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, el);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h expected %h (a=%h b=%h op=%b)",
                     name, result, exp, a, b, op);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        div_op = 2'b00;
        dividend = '0;
        divisor = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reset done: got %b expected 1", done);
        end
        checks++;
        if (result !== 64'd0) begin
            errors++;
            $display("FAIL reset result: got %h expected 0", result);
        end
        for (int i = 0; i < 10; i++) begin
            dividend = $urandom;
            divisor  = $urandom;
            tick();
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL idle done cycle %0d: got %b expected 1", i, done);
            end
        end
    endtask

    task automatic test_divu_basic();
        logic [63:0] exp;
        exp = {32'd2, 32'd14};
        run_one("divu_100_7", 2'b01, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) begin
            dividend = $urandom;
            divisor  = $urandom;
            tick();
            checks++;
            if (result !== exp || done !== 1'b1) begin
                errors++;
                $display("FAIL hold cycle %0d: got %h done=%b expected %h done=1",
                         i, result, done, exp);
            end
        end
    endtask

    task automatic test_signed();
        run_one("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        checks++;
        if (result !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            errors++;
            $display("FAIL div_m7_2 const: got %h expected ffffffff_fffffffd", result);
        end
        run_one("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (result !== {32'h0, 32'h8000_0000}) begin
            errors++;
            $display("FAIL div_ovf const: got %h expected 00000000_80000000", result);
        end
    endtask

    task automatic test_div_zero();
        run_one("divu_5_0", 2'b01, 32'd5, 32'd0);
        checks++;
        if (result !== {32'd5, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL divu_5_0 const: got %h expected 00000005_ffffffff", result);
        end
        run_one("div_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0);
        checks++;
        if (result !== {32'hFFFF_FFFB, 32'h1}) begin
            errors++;
            $display("FAIL div_m5_0 const: got %h expected fffffffb_00000001", result);
        end
        run_one("div_p5_0", 2'b10, 32'd5, 32'd0);
    endtask

    task automatic test_op11();
        logic [63:0] held;
        held = result;
        div_op   = 2'b11;
        dividend = 32'd50;
        divisor  = 32'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (done !== 1'b1 || result !== held) begin
                errors++;
                $display("FAIL op11 cycle %0d: done=%b result=%h expected done=1 result=%h",
                         i, done, result, held);
            end
        end
        div_op = 2'b00;
    endtask

    task automatic test_busy_ignore();
        int rises;
        int first;
        logic prev;
        logic [63:0] exp;
        int el;
        rises = 0;
        first = 0;
        prev  = 1'b0;
        exp = model(2'b01, 32'd1000, 32'd3);
        el  = exp_lat(2'b01, 32'd1000, 32'd3);
        div_op   = 2'b01;
        dividend = 32'd1000;
        divisor  = 32'd3;
        tick();
        for (int c = 1; c <= 45; c++) begin
            if (done && !prev) begin
                rises++;
                if (first == 0) first = c;
            end
            prev = done;
            if (c >= 5 && c <= 20) begin
                div_op   = 2'b01;
                dividend = 32'd77;
                divisor  = 32'd5;
            end else begin
                div_op = 2'b00;
            end
            tick();
        end
        checks++;
        if (rises !== 1 || first !== el) begin
            errors++;
            $display("FAIL busy_ignore edges: got %0d rises first at %0d expected 1 at %0d",
                     rises, first, el);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL busy_ignore result: got %h expected %h", result, exp);
        end
    endtask

    task automatic test_reset_mid();
        div_op   = 2'b01;
        dividend = 32'd123456;
        divisor  = 32'd789;
        tick();
        div_op = 2'b00;
        for (int c = 1; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid: done=%b result=%h expected done=1 result=0",
                     done, result);
        end
        run_one("divu_9_3", 2'b01, 32'd9, 32'd3);
        checks++;
        if (result !== {32'd0, 32'd3}) begin
            errors++;
            $display("FAIL divu_9_3 const: got %h expected 00000000_00000003", result);
        end
    endtask

`ifdef DIV_EARLY_OUT_EN
    task automatic test_early_out();
        run_one("early_3_10", 2'b01, 32'd3, 32'd10);
        checks++;
        if (result !== {32'd3, 32'd0}) begin
            errors++;
            $display("FAIL early_3_10 const: got %h expected 00000003_00000000", result);
        end
        run_one("early_zero", 2'b10, 32'd0, 32'hFFFF_FFF0);
        run_one("early_neg", 2'b10, 32'hFFFF_FFFD, 32'd10);
    endtask
`endif

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 16);
                2:       b = -$urandom_range(1, 16);
                3:       b = {16'h0, 16'($urandom)};
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = {24'h0, 8'($urandom)};
            run_one("random", op, a, b);
            if ($urandom_range(0, 2) == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_op11();
        test_busy_ignore();
        test_reset_mid();
`ifdef DIV_EARLY_OUT_EN
        test_early_out();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
